// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: fetch, data and external memory port signals shared by the arbiter.
// The master modport is the arbiter's view. The slave modport is the requesters' and memory's view.
interface cpu_mem_arbiter_if;
    // fetch requester
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        if_valid;
    logic [47:0] if_rdata;
    // data requester
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    // external memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [47:0] mem_rdata;
    logic        mem_ack;

    modport master (
        input  if_req, if_addr, if_kill,
        output if_valid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_valid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output if_req, if_addr, if_kill,
        input  if_valid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_valid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one memory port between instruction fetch (48-bit reads) and the
// data stage (32-bit loads/stores). Data has priority. A streak cap makes sure fetch is not
// starved. A killed in-flight fetch is drained and its data is discarded.
// If mem_ack never arrives, a watchdog sets a sticky error flag.
module cpu_mem_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_mem_arbiter_if.master     bus,
    output logic                  err_timeout
);

    localparam int unsigned SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] streak, streak_nxt;
    logic [TW-1:0] to_cnt;
    logic          streak_cap;
    logic          grant_d, grant_if;
    logic          deliver_d, deliver_if;
    logic          enter_wait;

    assign streak_cap = (streak == SW'(MAX_D_STREAK));

    // State and streak counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

    // Grant decision, completion detection and next-state logic
    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        grant_d    = 1'b0;
        grant_if   = 1'b0;
        deliver_d  = 1'b0;
        deliver_if = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.if_req) begin
                    streak_nxt = '0;
                end
                if (bus.d_req && !(bus.if_req && streak_cap)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                    // Only data grants made while fetch waits count toward the cap.
                    // The grant condition above already keeps the count below the cap here.
                    if (bus.if_req) begin
                        streak_nxt = streak + 1'b1;
                    end
                end else if (bus.if_req && !bus.if_kill) begin
                    grant_if   = 1'b1;
                    state_nxt  = BUSY_IF;
                    streak_nxt = '0;
                end
            end
            BUSY_D: begin
                if (bus.mem_ack) begin
                    deliver_d = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BUSY_IF: begin
                if (bus.mem_ack) begin
                    deliver_if = !bus.if_kill;
                    state_nxt  = IDLE;
                end else if (bus.if_kill) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_wait = (state_nxt != state) && (state_nxt != IDLE);

    // Memory port and response registers: fields are captured at grant and held until ack
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_valid  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_valid   <= 1'b0;
            bus.d_rdata   <= '0;
        end else begin
            bus.if_valid <= deliver_if;
            bus.d_valid  <= deliver_d;
            if (deliver_if) begin
                bus.if_rdata <= bus.mem_rdata;
            end
            if (deliver_d) begin
                bus.d_rdata <= bus.mem_rdata[31:0];
            end
            if (grant_d) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= bus.d_we;
                bus.mem_addr  <= bus.d_addr;
                bus.mem_wdata <= bus.d_wdata;
            end else if (grant_if) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= 1'b0;
                bus.mem_addr  <= bus.if_addr;
                bus.mem_wdata <= '0;
            end else if ((state != IDLE) && bus.mem_ack) begin
                bus.mem_req <= 1'b0;
            end
        end
    end

    // Watchdog: counts cycles without ack in any waiting state and sets a sticky flag at TIMEOUT
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else if (enter_wait) begin
            to_cnt <= '0;
        end else if ((state != IDLE) && !bus.mem_ack && (to_cnt != TW'(TIMEOUT))) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TW'(TIMEOUT - 1)) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: scoreboard bench for cpu_mem_arbiter. Stimulus queues the expected
// memory transactions and responses. A monitor pops these and compares them on each
// mem_req rise, if_valid and d_valid. A responder replays the queued memory acks.
module tb_cpu_mem_arbiter;

    localparam int unsigned TO = 20;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_t;

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } d_t;

    typedef struct {
        int unsigned delay;
        logic [47:0] rdata;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        err_timeout;
    logic        resp_ack;
    logic        man_ack;
    logic [47:0] resp_rdata;

    mem_t        exp_mem[$];
    logic [47:0] exp_if[$];
    d_t          exp_d[$];
    resp_t       resp_q[$];

    int total = 0;
    int bad   = 0;
    int n_valid = 0;

    cpu_mem_arbiter_if bus();

    assign bus.mem_ack   = resp_ack | man_ack;
    assign bus.mem_rdata = resp_rdata;

    cpu_mem_arbiter #(
        .MAX_D_STREAK(4),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen/missing with no matching expectation", name);
    endtask

    function automatic logic [159:0] all_outs();
        return {11'd0, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_valid,
                bus.if_rdata, bus.d_valid, bus.d_rdata, err_timeout};
    endfunction

    task automatic wait_valids(input int target, input int budget, input string name);
        int n = 0;
        while (n_valid < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n_valid < target) fail(name);
    endtask

    task automatic wait_mem_req(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_req && n < budget);
        if (!bus.mem_req) fail(name);
    endtask

    // Monitor: samples just after each rising edge and checks against the scoreboard queues
    initial begin : monitor
        logic        prev_req;
        mem_t        cur;
        mem_t        em;
        d_t          ed;
        logic [47:0] ei;
        prev_req = 1'b0;
        cur = '{1'b0, 32'h0, 32'h0};
        forever begin
            @(posedge clk);
            #1;
            if (bus.if_valid || bus.d_valid)
                chk("valid_exclusive", 160'(bus.if_valid & bus.d_valid), 160'(0));
            if (bus.if_valid) begin
                n_valid++;
                if (exp_if.size() == 0) fail("if_valid_unexpected");
                else begin
                    ei = exp_if.pop_front();
                    chk("if_rdata", 160'(bus.if_rdata), 160'(ei));
                end
            end
            if (bus.d_valid) begin
                n_valid++;
                if (exp_d.size() == 0) fail("d_valid_unexpected");
                else begin
                    ed = exp_d.pop_front();
                    if (ed.chk) chk("d_rdata", 160'(bus.d_rdata), 160'(ed.data));
                end
            end
            if (bus.mem_req && !prev_req) begin
                if (exp_mem.size() == 0) fail("mem_req_unexpected");
                else begin
                    em = exp_mem.pop_front();
                    chk("mem_we", 160'(bus.mem_we), 160'(em.we));
                    chk("mem_addr", 160'(bus.mem_addr), 160'(em.addr));
                    chk("mem_wdata", 160'(bus.mem_wdata), 160'(em.wdata));
                    cur = em;
                end
            end else if (bus.mem_req) begin
                chk("mem_stable", 160'({bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                    160'({cur.we, cur.addr, cur.wdata}));
            end
            prev_req = bus.mem_req;
        end
    end

    // Memory responder: acks each new request after its queued delay
    initial begin : responder
        resp_t r;
        resp_ack   = 1'b0;
        resp_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && resp_q.size() != 0) begin
                r = resp_q.pop_front();
                repeat (r.delay) @(negedge clk);
                resp_ack   = 1'b1;
                resp_rdata = r.rdata;
                @(negedge clk);
                resp_ack   = 1'b0;
                resp_rdata = '0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base;
        rst         = 1'b1;
        man_ack     = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.if_kill = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", all_outs(), '0);

        // single fetch, ack three cycles after mem_req
        resp_q.push_back('{2, 48'hA1B2C3D4E5F6});
        exp_mem.push_back('{1'b0, 32'h100, 32'h0});
        exp_if.push_back(48'hA1B2C3D4E5F6);
        base = n_valid;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        @(negedge clk);
        chk("fetch_latency", 160'(bus.mem_req), 160'(1));
        wait_valids(base + 1, 20, "t1_wait");
        bus.if_req = 1'b0;
        chk("fetch_req_drop", 160'(bus.mem_req), 160'(0));
        repeat (3) @(negedge clk);

        // store then load
        resp_q.push_back('{1, 48'h0});
        resp_q.push_back('{1, 48'h0000DEADBEEF});
        exp_mem.push_back('{1'b1, 32'h2000, 32'hDEADBEEF});
        exp_mem.push_back('{1'b0, 32'h2000, 32'h0});
        exp_d.push_back('{1'b0, 32'h0});
        exp_d.push_back('{1'b1, 32'hDEADBEEF});
        base = n_valid;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h2000;
        bus.d_wdata = 32'hDEADBEEF;
        wait_valids(base + 1, 20, "t2_store_wait");
        bus.d_we    = 1'b0;
        bus.d_wdata = 32'h0;
        wait_valids(base + 2, 20, "t2_load_wait");
        bus.d_req = 1'b0;
        repeat (3) @(negedge clk);

        // fairness: D,D,D,D,IF,D,D,D,D,IF
        for (int i = 0; i < 10; i++) begin
            resp_q.push_back('{0, {16'h00AA, 32'hC0000000 | 32'(i)}});
            if (i == 4 || i == 9) begin
                exp_mem.push_back('{1'b0, 32'h500, 32'h0});
                exp_if.push_back({16'h00AA, 32'hC0000000 | 32'(i)});
            end else begin
                exp_mem.push_back('{1'b0, 32'h4000, 32'h0});
                exp_d.push_back('{1'b1, 32'hC0000000 | 32'(i)});
            end
        end
        base = n_valid;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h500;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h4000;
        bus.d_wdata = 32'h0;
        wait_valids(base + 10, 100, "t3_wait");
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (3) @(negedge clk);

        // kill an in-flight fetch, redirect to 0x300
        resp_q.push_back('{6, 48'h111111111111});
        resp_q.push_back('{1, 48'h333344445555});
        exp_mem.push_back('{1'b0, 32'h100, 32'h0});
        exp_mem.push_back('{1'b0, 32'h300, 32'h0});
        exp_if.push_back(48'h333344445555);
        base = n_valid;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        wait_mem_req(10, "t4_req_wait");
        repeat (2) @(negedge clk);
        bus.if_kill = 1'b1;
        bus.if_addr = 32'h300;
        @(negedge clk);
        bus.if_kill = 1'b0;
        wait_valids(base + 1, 40, "t4_wait");
        bus.if_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_valid_count", 160'(n_valid), 160'(base + 1));

        // timeout: data grant with no ack
        exp_mem.push_back('{1'b1, 32'h7000, 32'hCAFEF00D});
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h7000;
        bus.d_wdata = 32'hCAFEF00D;
        wait_mem_req(10, "t5_req_wait");
        chk("t5_err_start", 160'(err_timeout), 160'(0));
        for (int k = 1; k <= int'(TO) + 3; k++) begin
            @(negedge clk);
            if (k == int'(TO) - 1) chk("t5_err_early", 160'(err_timeout), 160'(0));
            if (k == int'(TO)) chk("t5_err_rise", 160'(err_timeout), 160'(1));
        end
        chk("t5_err_sticky", 160'(err_timeout), 160'(1));
        chk("t5_req_held", 160'(bus.mem_req), 160'(1));
        bus.d_req = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_reset_clears", all_outs(), '0);
        rst = 1'b0;
        @(negedge clk);

        // reset in the middle of a data transaction, then a late ack
        exp_mem.push_back('{1'b1, 32'h6000, 32'h12345678});
        base = n_valid;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h6000;
        bus.d_wdata = 32'h12345678;
        wait_mem_req(10, "t6_req_wait");
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        bus.d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_outputs_zero", all_outs(), '0);
        end
        chk("t6_no_valid", 160'(n_valid), 160'(base));

        // back to normal operation from IDLE
        resp_q.push_back('{0, 48'h00000000ABCD});
        exp_mem.push_back('{1'b0, 32'h800, 32'h0});
        exp_if.push_back(48'h00000000ABCD);
        base = n_valid;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h800;
        @(negedge clk);
        chk("t7_latency", 160'(bus.mem_req), 160'(1));
        wait_valids(base + 1, 20, "t7_wait");
        bus.if_req = 1'b0;
        repeat (3) @(negedge clk);

        chk("exp_mem_empty", 160'(exp_mem.size()), 160'(0));
        chk("exp_if_empty", 160'(exp_if.size()), 160'(0));
        chk("exp_d_empty", 160'(exp_d.size()), 160'(0));
        chk("resp_q_empty", 160'(resp_q.size()), 160'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares the single external memory port between two requesters: the fetch stage (48-bit instruction reads) and the memory stage (32-bit data loads/stores).
- Fixed priority to data, with a fairness cap so fetch cannot starve.
- Supports abort of an in-flight fetch on pipeline kill (branch redirect); the aborted response is drained and discarded.
- Sits between cpu_fetch / the memory stage and the top-level memory interface.

Parameters:
- MAX_D_STREAK, default 4: maximum consecutive data grants while fetch is pending; the next grant goes to fetch.
- TIMEOUT, default 255: cycles in a BUSY state without mem_ack before err_timeout is raised.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- if_req  in  1  fetch request; held high with if_addr stable until if_valid or if_kill.
- if_addr  in  32  fetch byte address.
- if_kill  in  1  abort the outstanding fetch (pipeline redirect).
- if_valid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  48  instruction word.
- d_req  in  1  data request; held high with d_addr, d_we and d_wdata stable until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_valid  out  1  one-cycle pulse; load data valid or store complete.
- d_rdata  out  32  load data, taken from mem_rdata[31:0].
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  write data.
- mem_rdata  in  48  read data, valid with mem_ack.
- mem_ack  in  1  transaction complete; single-cycle pulse.
- err_timeout  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset (rst high at posedge): state IDLE; streak counter 0; timeout counter 0. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, if_valid, if_rdata, d_valid, d_rdata, err_timeout.
- Reset mid-transaction aborts it. No valid is issued. A late mem_ack arriving in IDLE is ignored.
- FSM states: IDLE, BUSY_IF, BUSY_D, DRAIN.
- IDLE, grant decision is registered:
  - d_req && !(if_req && streak==MAX_D_STREAK) → BUSY_D; streak increments, saturating at MAX_D_STREAK.
  - else if_req && !if_kill → BUSY_IF; streak clears.
  - else stay in IDLE.
  - On entering BUSY_*: capture address, we and wdata into mem_* registers and set mem_req=1.
  - Fetch grants have mem_we=0 and mem_wdata=0.
- Streak counter: clears on any fetch grant and whenever if_req is low in IDLE; only counts data grants made while fetch is waiting.
- BUSY_D, on mem_ack: mem_req←0; d_valid←1 for one cycle; d_rdata←mem_rdata[31:0]; → IDLE. d_rdata is updated on stores too (value is don't-care to the requester).
- BUSY_IF:
  - on mem_ack && !if_kill: if_valid←1 and if_rdata←mem_rdata; → IDLE.
  - on mem_ack && if_kill: no if_valid; → IDLE.
  - on if_kill without mem_ack: → DRAIN; mem_req stays high.
- DRAIN: wait for mem_ack; discard data; no valid; → IDLE.
- While in IDLE, if_kill only suppresses that cycle's fetch grant. The redirected fetch is granted on a later IDLE cycle using the new if_addr.
- Latency: request seen in IDLE at cycle N → mem_req high at N+1. mem_ack at cycle M → valid pulse and mem_req low at M+1, state back in IDLE at M+1, next grant decided at M+1, new mem_req at M+2.
- mem_req never stays asserted across a grant change; mem_addr, mem_we and mem_wdata hold constant while mem_req is high.
- Timeout: the counter resets on entering any BUSY/DRAIN state and increments each cycle without mem_ack. When it reaches TIMEOUT, err_timeout←1 (sticky). The FSM keeps waiting; it does not self-recover.
- if_valid and d_valid are never high in the same cycle. Each is high for at most one cycle per grant.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ack 3 cycles after mem_req with mem_rdata=48'hA1B2C3D4E5F6 → mem_addr=0x100, mem_we=0; if_valid pulses once with if_rdata=48'hA1B2C3D4E5F6; d_valid stays 0.
- Store then load: d_req with d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, then a load from 0x2000 with mem_rdata=0x0000DEADBEEF → mem_we=1 with mem_wdata=0xDEADBEEF on the first transaction; d_valid twice; d_rdata=0xDEADBEEF on the second.
- Fairness: d_req and if_req both held high continuously, memory acks each request after 1 cycle → grant order D,D,D,D,IF,D,D,D,D,IF with MAX_D_STREAK=4.
- Kill in flight: fetch granted at 0x100, if_kill pulsed before mem_ack, then if_req with if_addr=0x300 → no if_valid for 0x100; DRAIN consumes the ack; next mem_addr=0x300; if_valid delivers the 0x300 data.
- Timeout: grant a data request and never assert mem_ack → err_timeout rises exactly TIMEOUT cycles after mem_req rose and remains 1; mem_req stays 1.
- Reset mid-op: rst asserted while in BUSY_D, then mem_ack pulsed after rst deasserts → all outputs 0, no d_valid, FSM in IDLE.
